gcd_driver: RTL

// Initiator side of the gcd core interface. It accepts operand pairs from an upstream

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_req_fifo.sv | 56 +++++
 rtl/gcd_driver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared constants and FSM encoding for the gcd core driver.
// The state encoding is fixed so it can be observed on debug buses.
package gcd_pkg;

    localparam int GCD_W       = 32;
    localparam int GCD_DEPTH   = 4;
    localparam int GCD_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } gcd_state_e;

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous request FIFO holding {a, b} operand pairs.
// The pointers carry an extra wrap bit so that full and empty can be told apart.
module gcd_req_fifo #(
    parameter int W2    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W2-1:0] din,
    output logic [W2-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W2-1:0] mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          do_push_s;
    logic          do_pop_s;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // Read and write pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/gcd_driver.sv
// Sequencer between a host request port and a gcd core: queues operand pairs,
// issues them to the core one at a time and returns {a, b, gcd, err} in order.
module gcd_driver
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int DEPTH   = GCD_DEPTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] core_n1,
    output logic [W-1:0] core_n2,
    output logic         core_start,
    input  logic [W-1:0] core_out,
    input  logic         core_done,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_a,
    output logic [W-1:0] rsp_b,
    output logic [W-1:0] rsp_gcd,
    output logic         rsp_err
);

    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    gcd_state_e     state_r;
    gcd_state_e     state_s;
    logic [2*W-1:0] fifo_din_s;
    logic [2*W-1:0] fifo_dout_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           pop_s;
    logic           push_s;
    logic           ready_en_r;
    logic [W-1:0]   pair_a_s;
    logic [W-1:0]   pair_b_s;
    logic           zero_pair_s;
    logic           done_ok_s;
    logic           expired_s;
    logic [TW-1:0]  timer_r;

    assign fifo_din_s  = {req_a, req_b};
    assign pair_a_s    = fifo_dout_s[2*W-1:W];
    assign pair_b_s    = fifo_dout_s[W-1:0];
    assign zero_pair_s = (pair_a_s == {W{1'b0}}) || (pair_b_s == {W{1'b0}});
    assign pop_s       = (state_r == IDLE) && !fifo_empty_s;
    assign req_ready   = ready_en_r && (!fifo_full_s || pop_s);
    assign push_s      = req_valid && req_ready;
    // timer_r is zero only on the first WAIT cycle, where done may still be stale.
    assign done_ok_s   = (timer_r != {TW{1'b0}}) && core_done;
    assign expired_s   = (timer_r == T_LAST);

    gcd_req_fifo #(
        .W2    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    if (zero_pair_s) begin
                        state_s = RESP;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (done_ok_s || expired_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and request-port enable (held low until reset is released).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ready_en_r <= 1'b1;
        end
    end

    // Core operands, start pulse, timeout counter and response fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_n1    <= {W{1'b0}};
            core_n2    <= {W{1'b0}};
            core_start <= 1'b0;
            timer_r    <= {TW{1'b0}};
            rsp_valid  <= 1'b0;
            rsp_a      <= {W{1'b0}};
            rsp_b      <= {W{1'b0}};
            rsp_gcd    <= {W{1'b0}};
            rsp_err    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s && zero_pair_s) begin
                        // gcd(x,0)=x and gcd(0,0)=0, so OR gives the answer without the core.
                        rsp_a     <= pair_a_s;
                        rsp_b     <= pair_b_s;
                        rsp_gcd   <= pair_a_s | pair_b_s;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (pop_s) begin
                        core_n1    <= pair_a_s;
                        core_n2    <= pair_b_s;
                        core_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    timer_r <= {TW{1'b0}};
                end
                WAIT: begin
                    if (timer_r != {TW{1'b1}}) begin
                        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                    if (done_ok_s) begin
                        rsp_a     <= core_n1;
                        rsp_b     <= core_n2;
                        rsp_gcd   <= core_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (expired_s) begin
                        rsp_a     <= core_n1;
                        rsp_b     <= core_n2;
                        rsp_gcd   <= {W{1'b0}};
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
